// File: rtl/apb_pkg.sv
// apb_pkg: shared types for the APB master bridge.
// State encoding, captured request bundle and strobe helper.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = APB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] wstrb;
  } apb_req_t;

  // Reads must present an all-zero strobe on the bus.
  function automatic logic [APB_STRB_W-1:0] apb_strb(
    input logic                  write,
    input logic [APB_STRB_W-1:0] strb
  );
    return write ? strb : '0;
  endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// apb_timeout_ctr: counts ACCESS cycles without pready.
// expired flags the last allowed wait cycle.
module apb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired = (cnt_q >= LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready request channel to APB4 master.
// Optional ACCESS timeout when APB_TIMEOUT_EN is defined.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  output logic [3:0]        pwstrb,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [31:0]       prdata
);

  apb_state_e  state_q, state_d;
  apb_req_t    req_q, req_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        accept;
  logic        abort;
  logic        in_access;

  assign in_access = (state_q == ACCESS);

  assign req_ready = (state_q == IDLE) |
                     ((state_q == RESP) & rsp_ready);
  assign accept    = req_valid & req_ready;

`ifdef APB_TIMEOUT_EN
  logic tmo_expired;

  apb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q == SETUP),
    .inc    (in_access & ~pready),
    .expired(tmo_expired)
  );

  // pready on the final wait cycle still completes normally.
  assign abort = in_access & ~pready & tmo_expired;
`else
  logic unused_tmo;

  assign abort      = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    if (accept) begin
      req_d.addr  = APB_ADDR_W'(req_addr);
      req_d.write = req_write;
      req_d.wdata = req_wdata;
      req_d.wstrb = apb_strb(req_write, req_wstrb);
    end

    unique case (1'b1)
      (state_q == IDLE): begin
        if (accept) begin
          state_d = SETUP;
          psel_d  = 1'b1;
        end
      end
      (state_q == SETUP): begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      (state_q == ACCESS): begin
        if (pready || abort) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pready ? pslverr : 1'b1;
          rsp_rdata_d = (pready && !req_q.write) ? prdata : '0;
        end
      end
      (state_q == RESP): begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (req_valid) begin
            state_d = SETUP;
            psel_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign paddr     = ADDR_W'(req_q.addr);
  assign pwrite    = req_q.write;
  assign pwdata    = req_q.wdata;
  assign pwstrb    = req_q.wstrb;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed bench with a transaction-level model.
// Slave map: addr[20] -> pslverr, addr[24] -> never ready.
module tb_apb_master_bridge;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pwstrb;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .ADDR_W(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- APB slave ----------------
  logic [31:0] smem [logic [31:0]];
  int          acc_cnt;
  int          wait_n;
  logic [31:0] sw;

  initial begin
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 32'hBAD0_BAD0;
    acc_cnt = 0;
    wait_n  = 0;
  end

  // Outside ACCESS the slave drives junk that the bridge must ignore.
  always @(posedge clk) begin
    #1;
    if (psel && penable) begin
      pslverr = paddr[20];
      pready  = !paddr[24] && (acc_cnt >= wait_n);
      prdata  = smem.exists(paddr) ? smem[paddr] : 32'h0;
      if (pready && pwrite && !pslverr) begin
        sw = prdata;
        for (int b = 0; b < 4; b++)
          if (pwstrb[b]) sw[b*8 +: 8] = pwdata[b*8 +: 8];
        smem[paddr] = sw;
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      pready  = 1'b1;
      pslverr = 1'b1;
      prdata  = 32'hBAD0_BAD0;
    end
  end

  // ---------------- transaction model ----------------
  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_s;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_s;

  req_s        exp_req[$];
  rsp_s        exp_rsp[$];
  logic [31:0] mmem [logic [31:0]];
  req_s        cur;
  logic        in_xfer = 1'b0;
  logic        hold_v  = 1'b0;
  logic [31:0] hold_rd;
  logic        hold_er;

  function automatic logic [31:0] mread(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] bytemask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  always @(negedge clk) begin
    req_s r;
    rsp_s e;
    if (!rst_n) begin
      exp_req.delete();
      exp_rsp.delete();
      in_xfer = 1'b0;
      hold_v  = 1'b0;
    end else begin
      if (rsp_valid) begin
        chk1("mon_psel_in_resp", psel, 1'b0);
        if (hold_v) begin
          chk("mon_rdata_stable", rsp_rdata, hold_rd);
          chk1("mon_err_stable", rsp_err, hold_er);
        end
        if (rsp_ready) begin
          hold_v = 1'b0;
          if (exp_rsp.size() == 0) begin
            bound_fail("mon_rsp_unexpected");
          end else begin
            e = exp_rsp.pop_front();
            chk("mon_rsp_rdata", rsp_rdata, e.rdata);
            chk1("mon_rsp_err", rsp_err, e.err);
          end
        end else begin
          hold_v  = 1'b1;
          hold_rd = rsp_rdata;
          hold_er = rsp_err;
        end
      end else begin
        hold_v = 1'b0;
      end

      if (psel && !penable) begin
        if (exp_req.size() == 0) begin
          bound_fail("mon_setup_unexpected");
        end else begin
          cur     = exp_req.pop_front();
          in_xfer = 1'b1;
          chk("mon_paddr", paddr, cur.addr);
          chk1("mon_pwrite", pwrite, cur.write);
          chk("mon_pwdata", pwdata, cur.wdata);
          chk("mon_pwstrb", 32'(pwstrb),
              cur.write ? 32'(cur.strb) : 32'h0);
        end
      end else if (psel && penable) begin
        if (!in_xfer) begin
          bound_fail("mon_access_without_setup");
        end else begin
          chk("mon_paddr_stable", paddr, cur.addr);
          chk1("mon_pwrite_stable", pwrite, cur.write);
          chk("mon_pwdata_stable", pwdata, cur.wdata);
        end
      end else begin
        in_xfer = 1'b0;
      end

      if (req_valid && req_ready) begin
        r = '{req_addr, req_write, req_wdata, req_wstrb};
        exp_req.push_back(r);
        if (req_addr[24]) begin
`ifdef APB_TIMEOUT_EN
          exp_rsp.push_back('{32'h0, 1'b1});
`endif
        end else if (req_write) begin
          if (!req_addr[20])
            mmem[req_addr] = (mread(req_addr) & ~bytemask(req_wstrb)) |
                             (req_wdata & bytemask(req_wstrb));
          exp_rsp.push_back('{32'h0, req_addr[20]});
        end else begin
          exp_rsp.push_back('{mread(req_addr), req_addr[20]});
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_req(input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_wstrb = s;
  endtask

  task automatic handshake(input string name);
    bit got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    if (!got) bound_fail(name);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, output int pen,
                          output logic [31:0] rd, output logic er);
    bit got = 0;
    pen = 0;
    rd  = 32'hx;
    er  = 1'bx;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (penable) pen++;
      if (rsp_valid) begin
        got = 1;
        rd  = rsp_rdata;
        er  = rsp_err;
      end
    end
    if (!got) bound_fail(name);
  endtask

  task automatic xfer(input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s,
                      input int waits, output int pen,
                      output logic [31:0] rd, output logic er);
    wait_n    = waits;
    rsp_ready = 1'b1;
    put_req(a, w, d, s);
    handshake("xfer_handshake");
    wait_rsp("xfer_response", pen, rd, er);
    step();
  endtask

  int          pen;
  logic [31:0] rd;
  logic        er;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_write = 1'b0;
    req_wdata = 32'h0;
    req_wstrb = 4'h0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_psel", psel, 1'b0);
    chk1("rst_penable", penable, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk1("rst_pwrite", pwrite, 1'b0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_pwstrb", 32'(pwstrb), 32'h0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_req_ready", req_ready, 1'b1);
    step();
    rst_n = 1'b1;
    step();

    // 1: zero-wait write, cycle-exact latency
    wait_n    = 0;
    rsp_ready = 1'b1;
    put_req(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    chk1("t1_c0_req_ready", req_ready, 1'b1);
    chk1("t1_c0_psel", psel, 1'b0);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk1("t1_c1_psel", psel, 1'b1);
    chk1("t1_c1_penable", penable, 1'b0);
    chk("t1_c1_paddr", paddr, 32'h0000_0010);
    chk("t1_c1_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("t1_c1_pwstrb", 32'(pwstrb), 32'hF);
    chk1("t1_c1_pwrite", pwrite, 1'b1);
    step();
    @(negedge clk);
    chk1("t1_c2_psel", psel, 1'b1);
    chk1("t1_c2_penable", penable, 1'b1);
    chk1("t1_c2_rsp_valid", rsp_valid, 1'b0);
    step();
    @(negedge clk);
    chk1("t1_c3_rsp_valid", rsp_valid, 1'b1);
    chk1("t1_c3_rsp_err", rsp_err, 1'b0);
    chk("t1_c3_rsp_rdata", rsp_rdata, 32'h0);
    chk1("t1_c3_psel", psel, 1'b0);
    step();
    @(negedge clk);
    chk1("t1_c4_rsp_valid", rsp_valid, 1'b0);
    chk1("t1_c4_req_ready", req_ready, 1'b1);
    step();

    // 2: read with two wait states
    xfer(32'h0000_0010, 1'b0, 32'h0, 4'hF, 2, pen, rd, er);
    chk("t2_penable_cycles", pen, 3);
    chk("t2_rdata", rd, 32'hDEAD_BEEF);
    chk1("t2_err", er, 1'b0);

    // 3: slave error on read
    xfer(32'h0010_0000, 1'b0, 32'h0, 4'h0, 0, pen, rd, er);
    chk1("t3_err", er, 1'b1);
    chk("t3_rdata", rd, 32'h0);

    // partial strobes merge into the word
    xfer(32'h0000_0020, 1'b1, 32'h1122_3344, 4'hF, 1, pen, rd, er);
    chk("ws_penable_cycles", pen, 2);
    xfer(32'h0000_0020, 1'b1, 32'hAABB_CCDD, 4'h5, 0, pen, rd, er);
    chk1("ws_err", er, 1'b0);
    xfer(32'h0000_0020, 1'b0, 32'h0, 4'h0, 0, pen, rd, er);
    chk("ws_rdata", rd, 32'h11BB_33DD);
    xfer(32'h0010_0020, 1'b1, 32'h5555_AAAA, 4'hF, 0, pen, rd, er);
    chk1("we_err", er, 1'b1);
    chk("we_rdata", rd, 32'h0);

    // 4: response held while consumer stalls
    wait_n    = 0;
    rsp_ready = 1'b0;
    put_req(32'h0000_0020, 1'b0, 32'h0, 4'h0);
    handshake("t4_handshake");
    wait_rsp("t4_response", pen, rd, er);
    step();
    put_req(32'h0000_0030, 1'b1, 32'hCAFE_F00D, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("t4_rsp_valid", rsp_valid, 1'b1);
      chk("t4_rsp_rdata", rsp_rdata, 32'h11BB_33DD);
      chk1("t4_rsp_err", rsp_err, 1'b0);
      chk1("t4_req_ready", req_ready, 1'b0);
      chk1("t4_psel", psel, 1'b0);
      step();
    end

    // 5: back-to-back, no IDLE bubble
    rsp_ready = 1'b1;
    @(negedge clk);
    chk1("t5_req_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk1("t5_psel", psel, 1'b1);
    chk1("t5_penable", penable, 1'b0);
    chk("t5_paddr", paddr, 32'h0000_0030);
    chk1("t5_rsp_valid", rsp_valid, 1'b0);
    wait_rsp("t5_response", pen, rd, er);
    chk1("t5_err", er, 1'b0);
    step();
    xfer(32'h0000_0030, 1'b0, 32'h0, 4'h0, 0, pen, rd, er);
    chk("t5_readback", rd, 32'hCAFE_F00D);

    // 6: pready on the last allowed wait cycle completes normally
    xfer(32'h0000_0010, 1'b0, 32'h0, 4'h0, TMO - 1, pen, rd, er);
    chk("t6_edge_penable_cycles", pen, TMO);
    chk1("t6_edge_err", er, 1'b0);
    chk("t6_edge_rdata", rd, 32'hDEAD_BEEF);

`ifdef APB_TIMEOUT_EN
    xfer(32'h0100_0000, 1'b0, 32'h0, 4'h0, 0, pen, rd, er);
    chk("t6_tmo_penable_cycles", pen, TMO);
    chk1("t6_tmo_err", er, 1'b1);
    chk("t6_tmo_rdata", rd, 32'h0);
    put_req(32'h0100_0000, 1'b0, 32'h0, 4'h0);
    handshake("t6_hang_handshake");
    repeat (4) step();
`else
    put_req(32'h0100_0000, 1'b0, 32'h0, 4'h0);
    handshake("t6_hang_handshake");
    repeat (100) step();
    @(negedge clk);
    chk1("t6_hold_psel", psel, 1'b1);
    chk1("t6_hold_penable", penable, 1'b1);
    chk1("t6_hold_rsp_valid", rsp_valid, 1'b0);
    step();
`endif

    // reset in the middle of ACCESS
    @(negedge clk);
    chk1("t6_pre_rst_penable", penable, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("t6_rst_psel", psel, 1'b0);
    chk1("t6_rst_penable", penable, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("t6_post_rst_rsp_valid", rsp_valid, 1'b0);
      chk1("t6_post_rst_psel", psel, 1'b0);
    end
    chk("end_pending_rsp", exp_rsp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
